// File: rtl/fetch_pkg.sv
// Shared types for the fetch path: widths, FSM encoding and buffer entry layout.
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer: DEPTH-entry synchronous FIFO of {pc, instr} with flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t      r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      assert (!(w_do_push && !w_do_pop && o_full))
        else $error("fetch_buffer overflow");
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem reads against buffer credit, handles redirect/halt.
// States: IDLE first cycle after reset | RUN issuing | STALL out of credit | HALT halt held
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_code,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [1:0]  state_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;
  logic            w_req;
  logic            w_has_credit;
  logic            w_pop;
  logic            w_buf_full;
  logic            w_buf_empty;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

  // Credit uses registered occupancy only; a same-cycle pop does not free a slot.
  assign w_has_credit = !w_buf_full && ((w_count + CW'(r_inflight)) < CW'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_IDLE) begin
      w_state_nxt = ST_RUN;
    end else if (halt) begin
      w_state_nxt = ST_HALT;
    end else if (redirect_valid) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   w_state_nxt = w_has_credit ? ST_RUN : ST_STALL;
        ST_STALL: w_state_nxt = w_has_credit ? ST_RUN : ST_STALL;
        ST_HALT:  w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_req = (r_state == ST_RUN) && w_has_credit && !halt && !redirect_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) r_inflight_pc <= r_pc;
      if (redirect_valid) r_pc <= align_pc(redirect_pc);
      else if (w_req)     r_pc <= r_pc + XLEN'(INSTR_BYTES);
    end
  end

  assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};
  assign w_pop       = !w_buf_empty && instr_ready;

  // Redirect doubles as flush; the buffer drops the in-flight push in that cycle.
  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_buf_full),
    .o_empty     (w_buf_empty)
  );

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = !w_buf_empty;
  assign instr_code  = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign state_o     = r_state;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 1-cycle synchronous memory returning addr ^ 32'hA5A5_0000.
module tb_fetch_ctrl;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [1:0]  state_o;

  int          n_pass  = 0;
  int          n_total = 0;
  int          n_pop   = 0;
  int          p0;
  int          n_req;
  logic [31:0] exp_pc  = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ MASK;
  end

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_code     (instr_code),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .state_o        (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Every accepted word must be the next sequential PC with its memory pattern.
  task automatic step();
    #2;
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      chk("pop_pc", instr_pc, exp_pc);
      chk("pop_code", instr_code, exp_pc ^ MASK);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = rdy;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    exp_pc = 32'h0;
  endtask

  initial begin
    // reset values and cold-start latency/throughput
    do_reset(1'b1);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_code", instr_code, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    step();
    chk("c1_state", 32'(state_o), 32'd1);
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    step();
    chk("c2_req", 32'(imem_req), 32'd1);
    chk("c2_addr", imem_addr, 32'h4);
    chk("c2_valid", 32'(instr_valid), 32'd0);
    step();
    chk("c3_valid", 32'(instr_valid), 32'd1);
    chk("c3_pc", instr_pc, 32'h0);
    chk("c3_code", instr_code, 32'hA5A5_0000);
    p0 = n_pop;
    repeat (5) step();
    chk("stream_pops", 32'(n_pop - p0), 32'd5);
    chk("c8_valid", 32'(instr_valid), 32'd1);
    chk("c8_pc", instr_pc, 32'd20);
    chk("c8_addr", imem_addr, 32'd28);

    // backpressure fills exactly DEPTH entries, then drains in order
    do_reset(1'b0);
    n_req = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (imem_req) n_req++;
    end
    chk("bp_reqs", 32'(n_req), 32'd4);
    chk("bp_state", 32'(state_o), 32'd2);
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_hold_pc", instr_pc, 32'h0);
    chk("bp_hold_code", instr_code, 32'hA5A5_0000);
    instr_ready = 1'b1;
    p0 = n_pop;
    repeat (8) step();
    chk("bp_drain_pops", 32'(n_pop - p0), 32'd8);

    // redirect with 3 buffered + 1 in flight
    do_reset(1'b0);
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    chk("rd_req", 32'(imem_req), 32'd0);
    chk("rd_valid_before", 32'(instr_valid), 32'd1);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rd_valid_after", 32'(instr_valid), 32'd0);
    chk("rd_state", 32'(state_o), 32'd1);
    chk("rd_req_new", 32'(imem_req), 32'd1);
    chk("rd_addr_new", imem_addr, 32'h0000_0100);
    exp_pc      = 32'h0000_0100;
    instr_ready = 1'b1;
    p0 = n_pop;
    repeat (6) step();
    chk("rd_pops", 32'(n_pop - p0), 32'd4);

    // halt mid-stream drains the buffer, then resumes sequentially
    halt  = 1'b1;
    n_req = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (imem_req) n_req++;
      step();
    end
    chk("halt_reqs", 32'(n_req), 32'd0);
    chk("halt_state", 32'(state_o), 32'd3);
    chk("halt_drained", 32'(instr_valid), 32'd0);
    halt = 1'b0;
    #1;
    chk("halt_exit_req", 32'(imem_req), 32'd0);
    step();
    chk("resume_state", 32'(state_o), 32'd1);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, exp_pc);
    p0 = n_pop;
    repeat (6) step();
    chk("resume_pops", 32'(n_pop - p0), 32'd4);

    // redirect and halt together end in HALT at the new PC
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0201;
    #1;
    chk("rdh_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rdh_state", 32'(state_o), 32'd3);
    chk("rdh_valid", 32'(instr_valid), 32'd0);
    chk("rdh_addr", imem_addr, 32'h0000_0200);
    exp_pc = 32'h0000_0200;
    halt   = 1'b0;
    step();
    chk("rdh_run", 32'(state_o), 32'd1);
    chk("rdh_run_addr", imem_addr, 32'h0000_0200);
    repeat (4) step();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    p0 = n_pop;
    repeat (6) step();
    chk("wrap_pops", 32'(n_pop - p0), 32'd4);
    chk("wrap_head", instr_pc, 32'h0000_0008);

    // reset while a response is in flight
    #1;
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_code", instr_code, 32'h0);
    chk("mid_rst_pc", instr_pc, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    step();
    step();
    reset  = 1'b1;
    exp_pc = 32'h0;
    step();
    step();
    chk("post_rst_c2_valid", 32'(instr_valid), 32'd0);
    step();
    chk("post_rst_c3_valid", 32'(instr_valid), 32'd1);
    chk("post_rst_pc", instr_pc, 32'h0);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer between the PC and the synchronous instruction memory (1-cycle read latency).
- Owns the PC and issues one read per cycle while buffer credit exists.
- Captures returning words, tagged with their PC, into a small FIFO and presents them to decode through a valid/ready handshake.
- Supports redirect (branch/jump) with flush of buffered and in-flight words, plus a halt request.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 4, instruction buffer entries (power of 2, >= 2).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
redirect_valid  input  1  load redirect_pc this cycle and flush
redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0
halt  input  1  level; while high no new reads are issued
imem_req  output  1  read strobe to instruction memory
imem_addr  output  32  read address, equals PC when imem_req=1
imem_rdata  input  32  read data, valid the cycle after imem_req
instr_valid  output  1  buffer head valid
instr_code  output  32  buffer head instruction
instr_pc  output  32  PC of buffer head
instr_ready  input  1  decode accepts head when instr_valid & instr_ready
state_o  output  2  current FSM state, for debug

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_PC, FIFO empty, inflight=0.
  - imem_req=0, instr_valid=0, instr_code=0, instr_pc=0, state=IDLE.
- FSM states: IDLE=0, RUN=1, STALL=2, HALT=3.
  - IDLE -> RUN on the first clock after reset is released. No request is issued in IDLE.
  - RUN: imem_req=1 when count+inflight < DEPTH and halt=0 and redirect_valid=0. On issue, PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - RUN -> STALL when count+inflight >= DEPTH; STALL -> RUN when credit returns. No request is issued in STALL.
  - Any state except IDLE -> HALT while halt=1. HALT -> RUN when halt=0. Buffered words keep draining in HALT.
- Issue credit: a pop in the same cycle is not credited. Credit is count+inflight as registered at the start of the cycle.
- inflight register: set to 1 in a cycle with imem_req=1, otherwise 0.
- Capture: when inflight=1, push {PC_issued, imem_rdata} at the end of that cycle.
- Latency: imem_req in cycle N -> instr_valid=1 in cycle N+2 (no bypass).
- Throughput: sustained 1 instruction/cycle with instr_ready=1 and DEPTH>=4.
- Pop: instr_valid & instr_ready removes the head.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - The FIFO never overflows; overflow is asserted in simulation.
- Redirect (redirect_valid=1):
  - PC <= {redirect_pc[31:2],2'b00}; no request that cycle.
  - FIFO is cleared at the end of the cycle; instr_valid=0 the next cycle.
  - The in-flight response is discarded: no push in the following cycle.
  - A pop in the redirect cycle is still a valid handshake.
  - First request at the new PC is issued the next cycle if halt=0.
- Redirect and halt in the same cycle: redirect is applied, then state=HALT.
- Redirect while in HALT updates PC and flushes; state stays HALT.
- Outputs: instr_code and instr_pc are held stable while instr_valid=1 and instr_ready=0.
- imem_addr equals PC in every cycle; imem_req qualifies it.
- Reset asserted mid-operation: immediate return to reset values; an in-flight response is dropped.

Decomposition:
- Package fetch_pkg: XLEN=32, INSTR_BYTES=4, state enum {IDLE,RUN,STALL,HALT}, fetch-entry struct {pc, instr}.
- Sub-module fetch_buffer: DEPTH-entry synchronous FIFO with push/pop/flush, count, full/empty, same clk/reset.
- fetch_ctrl keeps the FSM, PC and credit logic.

Test Plan:
- Reset then instr_ready=1, memory returns addr^32'hA5A5_0000 -> imem_req first in cycle 1. instr_valid from cycle 3 with instr_pc 0,4,8,... one per cycle, no gaps.
- instr_ready=0 for 10 cycles -> exactly 4 entries captured (pc 0,4,8,12), imem_req low, state=STALL. Release -> pcs 0..12 then 16 in order, no loss or duplicates.
- Redirect to 32'h0000_0103 while 3 words are buffered and 1 is in flight -> next instr_pc sequence 0x100, 0x104, ...; no word from old PCs appears.
- halt=1 for 5 cycles mid-stream -> no imem_req, buffer drains, state=HALT. halt=0 -> fetch resumes at the next sequential PC.
- PC near top (redirect to 32'hFFFF_FFF8) -> instr_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert reset in the cycle after a request -> outputs at reset values immediately. After release, the first instr_pc is RESET_PC; the stale response is never delivered.
